// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot decoder family.
// State encoding, select-width limits and the one-hot decode function.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DIRECT = 2'b01,
    SCAN   = 2'b10
  } state_e;

  localparam int unsigned N_MIN = 1;
  localparam int unsigned N_MAX = 6;

  function automatic bit n_legal(
    input int unsigned n
  );
    return (n >= N_MIN) && (n <= N_MAX);
  endfunction

  // Widest supported decode; callers cast down to 2^N bits.
  function automatic logic [63:0] onehot(
    input logic [5:0] s
  );
    return 64'd1 << s;
  endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// Control, select handshake and decoded-output bundle for scan_decoder.
// master drives controls and selects; slave is the decoder.
interface scan_decoder_if #(
  parameter int unsigned N       = 3,
  parameter int unsigned DWELL_W = 8
);

  localparam int unsigned W = 1 << N;

  logic               en;
  logic               mode;
  logic               sel_valid;
  logic [N-1:0]       sel;
  logic               sel_ready;
  logic [DWELL_W-1:0] dwell;
  logic [W-1:0]       y;
  logic [N-1:0]       idx;
  logic               wrap;

  modport master (
    output en,
    output mode,
    output sel_valid,
    output sel,
    output dwell,
    input  sel_ready,
    input  y,
    input  idx,
    input  wrap
  );

  modport slave (
    input  en,
    input  mode,
    input  sel_valid,
    input  sel,
    input  dwell,
    output sel_ready,
    output y,
    output idx,
    output wrap
  );

endinterface

// File: rtl/scan_decoder_core.sv
// Combinational N-to-2^N decode with optional one-cold output.
// i_act=0 yields the all-inactive pattern.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic [N-1:0]      i_sel,
  input  logic              i_act,
  output logic [(1<<N)-1:0] o_y
);

  localparam int unsigned W = 1 << N;

  logic [W-1:0] w_dec;

  assign w_dec = i_act ? W'(onehot(6'(i_sel))) : '0;
  assign o_y   = ACTIVE_LOW ? ~w_dec : w_dec;

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with handshaked direct mode and
// a dwell-timed auto-scan mode for round-robin strobing.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned N          = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  scan_decoder_if.slave bus
);

  localparam int unsigned W = 1 << N;
  localparam logic [N-1:0] IDX_MAX = N'(W - 1);
  localparam logic [W-1:0] Y_OFF = ACTIVE_LOW ? '1 : '0;

  if (!n_legal(N)) begin : g_bad_n
    $error("scan_decoder: N must be within 1..6");
  end

  state_e             r_state;
  logic [N-1:0]       r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_act;
  logic [W-1:0]       r_y;
  logic               r_wrap;

  state_e             w_st;
  logic [N-1:0]       w_idx;
  logic [DWELL_W-1:0] w_cnt;
  logic               w_act;
  logic               w_wrap;
  logic               w_acc;
  logic [W-1:0]       w_y;

  assign bus.sel_ready = bus.en & ~bus.mode;
  assign w_acc         = bus.sel_valid & bus.sel_ready;

  always_comb begin
    w_st   = r_state;
    w_idx  = r_idx;
    w_cnt  = r_cnt;
    w_act  = r_act;
    w_wrap = 1'b0;
    if (!bus.en) begin
      w_st  = IDLE;
      w_act = 1'b0;
      w_cnt = '0;
    end else begin
      unique case (r_state)
        IDLE, DIRECT: begin
          if (bus.mode) begin
            w_st  = SCAN;
            w_idx = '0;
            w_act = 1'b1;
            w_cnt = '0;
          end else begin
            // A transfer offered on the entry cycle is taken,
            // since sel_ready is already high there.
            w_st = DIRECT;
            if (w_acc) begin
              w_idx = bus.sel;
              w_act = 1'b1;
            end
          end
        end
        SCAN: begin
          if (!bus.mode) begin
            w_st  = DIRECT;
            w_cnt = '0;
          end else if (r_cnt >= bus.dwell) begin
            w_cnt  = '0;
            w_idx  = r_idx + 1'b1;
            w_wrap = (r_idx == IDX_MAX);
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_st  = IDLE;
          w_act = 1'b0;
          w_cnt = '0;
        end
      endcase
    end
  end

  decoder_core #(
    .N          (N),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .i_sel (w_idx),
    .i_act (w_act),
    .o_y   (w_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_act   <= 1'b0;
      r_y     <= Y_OFF;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_st;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_act   <= w_act;
      r_y     <= w_y;
      r_wrap  <= w_wrap;
    end
  end

  assign bus.y    = r_y;
  assign bus.idx  = r_idx;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: active-high and active-low
// instances share one stimulus stream and one reference model.
module tb_scan_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;
  logic [3:0] dwell;

  scan_decoder_if #(.N(3), .DWELL_W(4)) bus_h ();
  scan_decoder_if #(.N(3), .DWELL_W(4)) bus_l ();

  assign bus_h.en        = en;
  assign bus_h.mode      = mode;
  assign bus_h.sel_valid = sel_valid;
  assign bus_h.sel       = sel;
  assign bus_h.dwell     = dwell;
  assign bus_l.en        = en;
  assign bus_l.mode      = mode;
  assign bus_l.sel_valid = sel_valid;
  assign bus_l.sel       = sel;
  assign bus_l.dwell     = dwell;

  scan_decoder #(.N(3), .DWELL_W(4), .ACTIVE_LOW(1'b0)) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_h)
  );

  scan_decoder #(.N(3), .DWELL_W(4), .ACTIVE_LOW(1'b1)) u_l (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  typedef struct {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: 0 idle, 1 direct, 2 scan
  int m_st  = 0;
  int m_idx = 0;
  int m_cnt = 0;
  bit m_on  = 1'b0;
  bit m_wrap = 1'b0;

  function void model_step(bit r, bit e, bit m, bit v, int s, int d);
    m_wrap = 1'b0;
    if (!r) begin
      m_st = 0; m_idx = 0; m_cnt = 0; m_on = 1'b0;
    end else if (!e) begin
      m_st = 0; m_cnt = 0; m_on = 1'b0;
    end else if (m_st == 2 && m) begin
      if (m_cnt >= d) begin
        m_cnt = 0;
        if (m_idx == 7) m_wrap = 1'b1;
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end else if (m) begin
      m_st = 2; m_idx = 0; m_cnt = 0; m_on = 1'b1;
    end else if (m_st == 2) begin
      m_st = 1; m_cnt = 0;
    end else begin
      m_st = 1;
      if (v) begin
        m_idx = s;
        m_on  = 1'b1;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit e, input bit m,
                       input bit v, input int s, input int d);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; mode = m; sel_valid = v;
    sel = 3'(s); dwell = 4'(d);
    model_step(r, e, m, v, s, d);
    x.y    = m_on ? 8'(1 << m_idx) : 8'h00;
    x.idx  = 3'(m_idx);
    x.wrap = m_wrap;
    x.rdy  = e & ~m;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, req);
    end
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("y_hi",   bus_h.y, x.y);
        chk("y_lo",   bus_l.y, ~x.y);
        chk("idx_hi", 8'(bus_h.idx), 8'(x.idx));
        chk("idx_lo", 8'(bus_l.idx), 8'(x.idx));
        chk("wrap_hi", 8'(bus_h.wrap), 8'(x.wrap));
        chk("wrap_lo", 8'(bus_l.wrap), 8'(x.wrap));
        chk("rdy",    8'(bus_h.sel_ready), 8'(x.rdy));
      end
    end
  end

  initial begin
    bit rr, re, rm;
    en = 1'b1; mode = 1'b1; sel_valid = 1'b0; sel = '0; dwell = '0;
    // reset held with en=1 mode=1
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    // direct sweep with a gap
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 1, i, 0);
    drive(1, 1, 0, 0, 5, 0);
    drive(1, 1, 0, 0, 2, 0);
    drive(1, 1, 0, 1, 3, 0);
    // scan, dwell 2, over one full period plus
    repeat (30) drive(1, 1, 1, 0, 0, 2);
    repeat (12) drive(1, 1, 1, 0, 0, 0);
    // dwell 9 lowered to 1 at count 5
    for (int k = 0; k < 20 && m_cnt != 5; k++) drive(1, 1, 1, 0, 0, 9);
    drive(1, 1, 1, 0, 0, 1);
    drive(1, 1, 1, 0, 0, 1);
    // switch to direct while showing index 4
    for (int k = 0; k < 40 && m_idx != 4; k++) drive(1, 1, 1, 0, 0, 1);
    repeat (3) drive(1, 1, 0, 0, 0, 1);
    // disable mid-scan and ignored offers
    repeat (5) drive(1, 1, 1, 0, 0, 1);
    drive(1, 0, 1, 0, 0, 1);
    drive(1, 0, 0, 1, 3, 1);
    drive(1, 0, 1, 1, 6, 1);
    repeat (4) drive(1, 1, 1, 1, 6, 1);
    // reset at index 5
    for (int k = 0; k < 40 && m_idx != 5; k++) drive(1, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 0, 0, 0);
    repeat (10) drive(1, 1, 1, 0, 0, 0);
    // randomized traffic
    rm = 1'b1;
    repeat (400) begin
      rr = ($urandom_range(0, 49) != 0);
      re = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0) rm = ~rm;
      drive(rr, re, rm, 1'($urandom), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)));
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
